// File: rtl/main_fsm_pkg.sv
// Shared encodings for the multicycle controller: state type, opcodes, mux selects, ALUOp.
// Also reused by the ALU decoder so both blocks agree on the ALUOp meaning.
package main_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ERROR    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Where DECODE goes for a given opcode; unknown opcodes halt or fall back to FETCH.
    function automatic state_t decode_target(input logic [6:0] op, input bit halt);
        case (op)
            OP_LW, OP_SW: return S_MEMADR;
            OP_RTYPE:     return S_EXECUTER;
            OP_ITYPE:     return S_EXECUTEI;
            OP_JAL:       return S_JAL;
            OP_BEQ:       return S_BEQ;
            default:      return halt ? S_ERROR : S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V main controller: state register plus Moore output decode.
// Optional feature: define MAIN_FSM_MEM_WAIT_EN to add MemReady wait states on memory cycles.
module main_fsm
    import main_fsm_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [6:0] OP,
    input  logic       Zero,
`ifdef MAIN_FSM_MEM_WAIT_EN
    input  logic       MemReady,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state;
    logic   mem_ready;

`ifdef MAIN_FSM_MEM_WAIT_EN
    assign mem_ready = MemReady;
`else
    assign mem_ready = 1'b1;
`endif

    // OP is still held in the instruction register during MEMADR, so lw/sw are split there.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (mem_ready) state <= S_DECODE;
                S_DECODE:   state <= decode_target(OP, ILLEGAL_HALT);
                S_MEMADR:   state <= (OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
                S_MEMWRITE: if (mem_ready) state <= S_FETCH;
                S_EXECUTER, S_EXECUTEI, S_JAL: state <= S_ALUWB;
                S_MEMWB, S_ALUWB, S_BEQ:       state <= S_FETCH;
                S_ERROR:    state <= S_ERROR;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ALUOp     = ALUOP_ADD;
        Illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALUOP_SUB;
                PCWrite = Zero;
            end
            S_ERROR:    Illegal = 1'b1;
            default: ;
        endcase
        // Reset holds every write enable off even though the FETCH selects are shown.
        if (!RESET) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

    assign State = state;

endmodule

// File: tb/tb_main_fsm.sv
// Randomized instruction-stream bench for main_fsm (halting and NOP-on-illegal builds side by side).
// Per-instruction state sequences are queued from the instruction table and compared cycle by cycle.
module tb_main_fsm;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [6:0] OP = 7'd0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       h_pcw, h_adr, h_mw, h_irw, h_rw, h_ill;
    logic [1:0] h_res, h_sa, h_sb, h_aop;
    logic [3:0] h_state;
    logic       n_pcw, n_adr, n_mw, n_irw, n_rw, n_ill;
    logic [1:0] n_res, n_sa, n_sb, n_aop;
    logic [3:0] n_state;

    main_fsm #(.ILLEGAL_HALT(1'b1)) dut_halt (
        .CLK(CLK), .RESET(RESET), .OP(OP), .Zero(Zero),
`ifdef MAIN_FSM_MEM_WAIT_EN
        .MemReady(mem_ready),
`endif
        .PCWrite(h_pcw), .AdrSrc(h_adr), .MemWrite(h_mw), .IRWrite(h_irw),
        .RegWrite(h_rw), .ResultSrc(h_res), .ALUSrcA(h_sa), .ALUSrcB(h_sb),
        .ALUOp(h_aop), .Illegal(h_ill), .State(h_state)
    );

    main_fsm #(.ILLEGAL_HALT(1'b0)) dut_nop (
        .CLK(CLK), .RESET(RESET), .OP(OP), .Zero(Zero),
`ifdef MAIN_FSM_MEM_WAIT_EN
        .MemReady(mem_ready),
`endif
        .PCWrite(n_pcw), .AdrSrc(n_adr), .MemWrite(n_mw), .IRWrite(n_irw),
        .RegWrite(n_rw), .ResultSrc(n_res), .ALUSrcA(n_sa), .ALUSrcB(n_sb),
        .ALUOp(n_aop), .Illegal(n_ill), .State(n_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    // scoreboard: each entry is {ends_in_halt_after_this, state}
    logic [4:0] exp_q[$];
    logic [6:0] forced_ops[$];
    bit         halted;
    int         checks = 0;
    int         errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output table per state: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Illegal}
    function automatic logic [13:0] exp_outs(input int st, input logic z, input logic rst, input logic mr);
        logic pc, adr, mw, irw, rw, ill;
        logic [1:0] res, sa, sb, aop;
        {pc, adr, mw, irw, rw, ill} = 6'd0;
        {res, sa, sb, aop} = 8'd0;
        case (st)
            0:  begin pc = mr; irw = mr; sb = 2'd2; res = 2'd2; end
            1:  begin sa = 2'd1; sb = 2'd1; end
            2:  begin sa = 2'd2; sb = 2'd1; end
            3:  adr = 1'b1;
            4:  begin res = 2'd1; rw = 1'b1; end
            5:  begin adr = 1'b1; mw = 1'b1; end
            6:  begin sa = 2'd2; aop = 2'd2; end
            7:  rw = 1'b1;
            8:  begin sa = 2'd2; sb = 2'd1; aop = 2'd2; end
            9:  begin sa = 2'd1; sb = 2'd2; pc = 1'b1; end
            10: begin sa = 2'd2; aop = 2'd1; pc = z; end
            15: ill = 1'b1;
            default: ;
        endcase
        if (!rst) {pc, irw, rw, mw, ill} = 5'd0;
        return {pc, adr, mw, irw, rw, res, sa, sb, aop, ill};
    endfunction

    function automatic logic [13:0] h_outs();
        return {h_pcw, h_adr, h_mw, h_irw, h_rw, h_res, h_sa, h_sb, h_aop, h_ill};
    endfunction

    function automatic logic [13:0] n_outs();
        return {n_pcw, n_adr, n_mw, n_irw, n_rw, n_res, n_sa, n_sb, n_aop, n_ill};
    endfunction

    // driver: choose the next instruction and queue its expected state walk
    task automatic start_instr();
        logic [6:0] op;
        int r;
        if (forced_ops.size() > 0) begin
            op = forced_ops.pop_front();
        end else begin
            r = $urandom_range(0, 7);
            case (r)
                0: op = 7'b0000011;
                1: op = 7'b0100011;
                2: op = 7'b0110011;
                3: op = 7'b0010011;
                4: op = 7'b1101111;
                5: op = 7'b1100011;
                default: op = 7'($urandom_range(0, 127));
            endcase
        end
        OP = op;
        exp_q.push_back(5'd0);
        case (op)
            7'b0000011: begin exp_q.push_back(5'd1); exp_q.push_back(5'd2); exp_q.push_back(5'd3); exp_q.push_back(5'd4); end
            7'b0100011: begin exp_q.push_back(5'd1); exp_q.push_back(5'd2); exp_q.push_back(5'd5); end
            7'b0110011: begin exp_q.push_back(5'd1); exp_q.push_back(5'd6); exp_q.push_back(5'd7); end
            7'b0010011: begin exp_q.push_back(5'd1); exp_q.push_back(5'd8); exp_q.push_back(5'd7); end
            7'b1101111: begin exp_q.push_back(5'd1); exp_q.push_back(5'd9); exp_q.push_back(5'd7); end
            7'b1100011: begin exp_q.push_back(5'd1); exp_q.push_back(5'd10); end
            default:    exp_q.push_back(5'h11);
        endcase
    endtask

    task automatic sample_outputs();
        logic [3:0] exp_n, exp_h;
        exp_n = exp_q[0][3:0];
        exp_h = halted ? 4'd15 : exp_n;
        check_eq("state_nop", 32'(n_state), 32'(exp_n));
        check_eq("outs_nop", 32'(n_outs()), 32'(exp_outs(int'(exp_n), Zero, 1'b1, mem_ready)));
        check_eq("state_halt", 32'(h_state), 32'(exp_h));
        check_eq("outs_halt", 32'(h_outs()), 32'(exp_outs(int'(exp_h), Zero, 1'b1, mem_ready)));
    endtask

    // Called just after a rising edge: memory states only move on when memory is ready.
    task automatic advance();
        logic [3:0] cur;
        bit stall;
        cur = exp_q[0][3:0];
        stall = !mem_ready && (cur == 4'd0 || cur == 4'd3 || cur == 4'd5);
        if (!stall) begin
            if (exp_q[0][4]) halted = 1'b1;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check_in_reset(input string tag);
        check_eq({tag, "_state_nop"}, 32'(n_state), 32'd0);
        check_eq({tag, "_state_halt"}, 32'(h_state), 32'd0);
        check_eq({tag, "_outs_nop"}, 32'(n_outs()), 32'(exp_outs(0, Zero, 1'b0, mem_ready)));
        check_eq({tag, "_outs_halt"}, 32'(h_outs()), 32'(exp_outs(0, Zero, 1'b0, mem_ready)));
    endtask

    // Asynchronous reset mid-cycle: state and enables must drop before the next edge.
    task automatic pulse_reset();
        #3 RESET = 1'b0;
        #1 check_in_reset("async_rst");
        exp_q.delete();
        halted = 1'b0;
        @(negedge CLK);
        #1 check_in_reset("held_rst");
        @(posedge CLK);
        #3 RESET = 1'b1;
    endtask

    initial begin
        int next_reset;
        bit mid_done;
        forced_ops.push_back(7'b0000011);
        forced_ops.push_back(7'b0100011);
        forced_ops.push_back(7'b1100011);
        forced_ops.push_back(7'b1100011);
        forced_ops.push_back(7'b1111111);
        halted = 1'b0;
        mid_done = 1'b0;
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1 check_in_reset("por");
        @(posedge CLK);
        #3 RESET = 1'b1;
        next_reset = 45;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge CLK);
            if (exp_q.size() == 0) start_instr();
            Zero = 1'($urandom_range(0, 1));
`ifdef MAIN_FSM_MEM_WAIT_EN
            mem_ready = ($urandom_range(0, 3) != 0);
`endif
            #1 sample_outputs();
            @(posedge CLK);
            advance();
            if (!mid_done && cyc > 70 && exp_q.size() > 0 && exp_q[0][3:0] == 4'd3) begin
                mid_done = 1'b1;
                pulse_reset();
                next_reset = cyc + $urandom_range(25, 60);
            end else if (cyc >= next_reset) begin
                pulse_reset();
                next_reset = cyc + $urandom_range(25, 60);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
